// File: rtl/rs_pkg.sv
// Sizes, slot payload type and shared helpers for the ALU reservation station.
package rs_pkg;

  localparam int unsigned WIDTH   = 31;
  localparam int unsigned ROB     = 2;
  localparam int unsigned C_WIDTH = 3;
  localparam int unsigned ENTRIES = 4;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);

  typedef logic [WIDTH:0]     data_t;
  typedef logic [ROB:0]       tag_t;
  typedef logic [C_WIDTH:0]   ctl_t;
  typedef logic [ENTRIES-1:0] vec_t;
  typedef logic [IDX_W-1:0]   idx_t;

  localparam ctl_t ALU_NOP = '1;

  typedef struct packed {
    logic  busy;
    logic  rdy1;
    logic  rdy2;
    data_t val1;
    data_t val2;
    tag_t  tag1;
    tag_t  tag2;
    tag_t  robInstr;
    ctl_t  aluCtl;
  } rs_entry_t;

  // Isolate the least-significant set bit.
  function automatic vec_t lowest_one_hot(input vec_t v);
    return v & (~v + vec_t'(1));
  endfunction

endpackage

// File: rtl/commonDataBus.sv
// Common data bus: one result broadcast per cycle, tagged with its ROB entry.
interface commonDataBus;
  import rs_pkg::*;

  logic  validBroadcast;
  tag_t  robEntry;
  data_t result;

  modport master (output validBroadcast, robEntry, result);
  modport reservation_station (input validBroadcast, robEntry, result);
endinterface

// File: rtl/alu_rs_age_matrix.sv
// Oldest-first select for the reservation station; present only when
// ALU_RS_AGE_SELECT_EN is defined.
`ifdef ALU_RS_AGE_SELECT_EN
module alu_rs_age_matrix #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRIES-1:0] alloc,
  input  logic [ENTRIES-1:0] free,
  input  logic               flush,
  input  logic [ENTRIES-1:0] req,
  output logic [ENTRIES-1:0] grant_c
);

  // older_q[i][j] set means slot j was dispatched before slot i.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] older_q [ENTRIES];
  logic [ENTRIES-1:0] older_d [ENTRIES];

  always_comb begin : next_age
    valid_d = (valid_q & ~free) | alloc;
    for (int i = 0; i < ENTRIES; i++) begin
      older_d[i] = alloc[i] ? (valid_q & ~free) : (older_q[i] & ~free);
      if (flush) older_d[i] = '0;
    end
    if (flush) valid_d = '0;
  end

  always_comb begin : oldest_pick
    grant_c = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      grant_c[i] = req[i] && ((older_q[i] & req) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : age_reg
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) older_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
    end
  end

endmodule
`endif

// File: rtl/alu_reservation_station.sv
// ALU reservation station: dispatch write, CDB wakeup, select and bypassed issue.
// Define ALU_RS_AGE_SELECT_EN for oldest-first select; default is lowest-index-first.
module alu_reservation_station
  import rs_pkg::*;
(
  input  logic  clk,
  input  logic  globalResetN,
  commonDataBus.reservation_station dataBus,
  input  logic  writeReq,
  input  logic  ready1,
  input  logic  ready2,
  input  data_t value1,
  input  data_t value2,
  input  tag_t  rob1,
  input  tag_t  rob2,
  input  tag_t  robInstr,
  input  ctl_t  ALUControl,
  input  logic  clear,
  input  logic  validCommit,
  input  logic  execute,
  output logic  full,
  output logic  issueValid,
  output tag_t  instrRob,
  output ctl_t  instrInfo,
  output data_t src1,
  output data_t src2
);

  rs_entry_t ent_q [ENTRIES];
  rs_entry_t ent_d [ENTRIES];
  vec_t      busy, wake1, wake2, req, grant, alloc, free;
  logic      flush, hit1, hit2;
  idx_t      sel;

  assign flush = clear & validCommit;

  // Per-slot CDB tag match and issue request
  always_comb begin : wakeup
    busy  = '0;
    wake1 = '0;
    wake2 = '0;
    req   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy[i]  = ent_q[i].busy;
      wake1[i] = ent_q[i].busy && !ent_q[i].rdy1 && dataBus.validBroadcast
                 && (dataBus.robEntry == ent_q[i].tag1);
      wake2[i] = ent_q[i].busy && !ent_q[i].rdy2 && dataBus.validBroadcast
                 && (dataBus.robEntry == ent_q[i].tag2);
      req[i]   = ent_q[i].busy && (ent_q[i].rdy1 || wake1[i])
                 && (ent_q[i].rdy2 || wake2[i]);
    end
  end

  assign full  = &busy;
  assign hit1  = dataBus.validBroadcast && (dataBus.robEntry == rob1);
  assign hit2  = dataBus.validBroadcast && (dataBus.robEntry == rob2);
  assign alloc = (writeReq && !full && !flush) ? lowest_one_hot(~busy) : '0;
  assign free  = execute ? grant : '0;

`ifdef ALU_RS_AGE_SELECT_EN
  alu_rs_age_matrix #(.ENTRIES(ENTRIES)) u_age (
    .clk     (clk),
    .rst_n   (globalResetN),
    .alloc   (alloc),
    .free    (free),
    .flush   (flush),
    .req     (req),
    .grant_c (grant)
  );
`else
  assign grant = lowest_one_hot(req);
`endif

  // Issue mux; slot 0 is shown when nothing is granted
  always_comb begin : issue_mux
    sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) sel = idx_t'(i);
    end
    issueValid = |grant;
    instrRob   = ent_q[sel].robInstr;
    instrInfo  = ent_q[sel].aluCtl;
    src1       = wake1[sel] ? dataBus.result : ent_q[sel].val1;
    src2       = wake2[sel] ? dataBus.result : ent_q[sel].val2;
  end

  always_comb begin : next_state
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (wake1[i]) begin
        ent_d[i].rdy1 = 1'b1;
        ent_d[i].val1 = dataBus.result;
      end
      if (wake2[i]) begin
        ent_d[i].rdy2 = 1'b1;
        ent_d[i].val2 = dataBus.result;
      end
      if (free[i]) begin
        ent_d[i].busy = 1'b0;
        ent_d[i].rdy1 = 1'b0;
        ent_d[i].rdy2 = 1'b0;
      end
      // A tag broadcast in the dispatch cycle is captured on the way in
      if (alloc[i]) begin
        ent_d[i].busy     = 1'b1;
        ent_d[i].rdy1     = ready1 | hit1;
        ent_d[i].rdy2     = ready2 | hit2;
        ent_d[i].val1     = (!ready1 && hit1) ? dataBus.result : value1;
        ent_d[i].val2     = (!ready2 && hit2) ? dataBus.result : value2;
        ent_d[i].tag1     = rob1;
        ent_d[i].tag2     = rob2;
        ent_d[i].robInstr = robInstr;
        ent_d[i].aluCtl   = ALUControl;
      end
      if (flush) begin
        ent_d[i].busy = 1'b0;
        ent_d[i].rdy1 = 1'b0;
        ent_d[i].rdy2 = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge globalResetN) begin : ent_reg
    if (!globalResetN) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i]        <= '0;
        ent_q[i].aluCtl <= ALU_NOP;
      end
    end else begin
      ent_q <= ent_d;
    end
  end

  // Dispatch into a full station is dropped; flag it without stopping
  always_ff @(posedge clk) begin : overflow_chk
    if (globalResetN && !flush) begin
      assert (!(writeReq && full))
        else $warning("alu_reservation_station: dispatch dropped, all slots busy");
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed plus random stimulus against a slot/queue reference model.
module tb_alu_reservation_station;
  import rs_pkg::*;

  logic  clk = 1'b0;
  logic  globalResetN;
  logic  writeReq, ready1, ready2, clear, validCommit, execute;
  data_t value1, value2;
  tag_t  rob1, rob2, robInstr;
  ctl_t  ALUControl;
  logic  full, issueValid;
  tag_t  instrRob;
  ctl_t  instrInfo;
  data_t src1, src2;

  commonDataBus cdb();

  alu_reservation_station dut (
    .clk          (clk),
    .globalResetN (globalResetN),
    .dataBus      (cdb),
    .writeReq     (writeReq),
    .ready1       (ready1),
    .ready2       (ready2),
    .value1       (value1),
    .value2       (value2),
    .rob1         (rob1),
    .rob2         (rob2),
    .robInstr     (robInstr),
    .ALUControl   (ALUControl),
    .clear        (clear),
    .validCommit  (validCommit),
    .execute      (execute),
    .full         (full),
    .issueValid   (issueValid),
    .instrRob     (instrRob),
    .instrInfo    (instrInfo),
    .src1         (src1),
    .src2         (src2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    busy;
    bit    r1;
    bit    r2;
    data_t v1;
    data_t v2;
    tag_t  t1;
    tag_t  t2;
    tag_t  rob;
    ctl_t  ctl;
  } ment_t;

  ment_t m [ENTRIES];
  int    order [$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cdb_hit(input tag_t t);
    return (cdb.validBroadcast === 1'b1) && (cdb.robEntry === t);
  endfunction

  function automatic void model_reset();
    foreach (m[i]) begin
      m[i].busy = 0; m[i].r1 = 0; m[i].r2 = 0;
      m[i].v1 = '0; m[i].v2 = '0; m[i].t1 = '0; m[i].t2 = '0;
      m[i].rob = '0; m[i].ctl = ALU_NOP;
    end
    order.delete();
  endfunction

  function automatic bit m_full();
    foreach (m[i]) if (!m[i].busy) return 0;
    return 1;
  endfunction

  function automatic bit m_req(input int i);
    return m[i].busy && (m[i].r1 || cdb_hit(m[i].t1)) && (m[i].r2 || cdb_hit(m[i].t2));
  endfunction

  function automatic int m_pick();
`ifdef ALU_RS_AGE_SELECT_EN
    foreach (order[k]) if (m_req(order[k])) return order[k];
`else
    for (int i = 0; i < int'(ENTRIES); i++) if (m_req(i)) return i;
`endif
    return -1;
  endfunction

  task automatic model_check();
    int s = m_pick();
    chk("full", 64'(full), 64'(m_full()));
    chk("issueValid", 64'(issueValid), 64'(s >= 0));
    if (s >= 0) begin
      chk("instrRob", 64'(instrRob), 64'(m[s].rob));
      chk("instrInfo", 64'(instrInfo), 64'(m[s].ctl));
      chk("src1", 64'(src1), 64'((!m[s].r1 && cdb_hit(m[s].t1)) ? cdb.result : m[s].v1));
      chk("src2", 64'(src2), 64'((!m[s].r2 && cdb_hit(m[s].t2)) ? cdb.result : m[s].v2));
    end
  endtask

  // Apply one clock edge worth of station rules to the model.
  function automatic void model_update();
    int s, slot;
    bit was_full;
    if (clear && validCommit) begin
      foreach (m[i]) begin m[i].busy = 0; m[i].r1 = 0; m[i].r2 = 0; end
      order.delete();
      return;
    end
    s = m_pick();
    was_full = m_full();
    slot = -1;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) if (!m[i].busy) slot = i;
    foreach (m[i]) begin
      if (m[i].busy && !m[i].r1 && cdb_hit(m[i].t1)) begin m[i].r1 = 1; m[i].v1 = cdb.result; end
      if (m[i].busy && !m[i].r2 && cdb_hit(m[i].t2)) begin m[i].r2 = 1; m[i].v2 = cdb.result; end
    end
    if (s >= 0 && execute) begin
      m[s].busy = 0; m[s].r1 = 0; m[s].r2 = 0;
      for (int k = 0; k < order.size(); k++) begin
        if (order[k] == s) begin order.delete(k); break; end
      end
    end
    if (writeReq && !was_full) begin
      m[slot].busy = 1;
      m[slot].r1   = ready1 || cdb_hit(rob1);
      m[slot].r2   = ready2 || cdb_hit(rob2);
      m[slot].v1   = (!ready1 && cdb_hit(rob1)) ? cdb.result : value1;
      m[slot].v2   = (!ready2 && cdb_hit(rob2)) ? cdb.result : value2;
      m[slot].t1   = rob1;
      m[slot].t2   = rob2;
      m[slot].rob  = robInstr;
      m[slot].ctl  = ALUControl;
      order.push_back(slot);
    end
  endfunction

  task automatic idle();
    writeReq = 0; ready1 = 0; ready2 = 0; value1 = '0; value2 = '0;
    rob1 = '0; rob2 = '0; robInstr = '0; ALUControl = '0;
    clear = 0; validCommit = 0; execute = 0;
    cdb.validBroadcast = 0; cdb.robEntry = '0; cdb.result = '0;
  endtask

  task automatic disp(input logic r1, input logic r2, input data_t v1, input data_t v2,
                      input tag_t t1, input tag_t t2, input tag_t rob, input ctl_t ctl);
    writeReq = 1; ready1 = r1; ready2 = r2; value1 = v1; value2 = v2;
    rob1 = t1; rob2 = t2; robInstr = rob; ALUControl = ctl;
  endtask

  task automatic bcast(input tag_t t, input data_t d);
    cdb.validBroadcast = 1; cdb.robEntry = t; cdb.result = d;
  endtask

  // Check model against DUT mid-cycle, then advance one edge.
  task automatic tick();
    #1;
    if (!globalResetN) model_reset();
    model_check();
    @(posedge clk);
    if (globalResetN) model_update();
    @(negedge clk);
  endtask

  initial begin
    tag_t exp_first, exp_second;
    globalResetN = 0;
    idle();
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_full", 64'(full), 64'(0));
    chk("reset_issueValid", 64'(issueValid), 64'(0));
    chk("reset_instrInfo", 64'(instrInfo), 64'(4'hF));
    chk("reset_instrRob", 64'(instrRob), 64'(0));
    chk("reset_src1", 64'(src1), 64'(0));
    @(negedge clk);
    globalResetN = 1;
    tick();

    // Ready dispatch issues the following cycle
    disp(1, 1, 32'd5, 32'hFFFF_FFFD, 3'd0, 3'd0, 3'd6, 4'd2);
    tick();
    idle();
    #1;
    chk("rdy_issueValid", 64'(issueValid), 64'(1));
    chk("rdy_src1", 64'(src1), 64'(32'd5));
    chk("rdy_src2", 64'(src2), 64'(32'hFFFF_FFFD));
    chk("rdy_instrRob", 64'(instrRob), 64'(3'd6));
    chk("rdy_instrInfo", 64'(instrInfo), 64'(4'd2));
    execute = 1;
    tick();

    // Wakeup with same-cycle bypass, then latched value
    idle();
    disp(0, 1, 32'd0, 32'd1, 3'd3, 3'd0, 3'd1, 4'd1);
    tick();
    idle();
    #1;
    chk("wait_issueValid", 64'(issueValid), 64'(0));
    bcast(3'd3, 32'h11);
    #1;
    chk("bypass_issueValid", 64'(issueValid), 64'(1));
    chk("bypass_src1", 64'(src1), 64'(32'h11));
    tick();
    idle();
    #1;
    chk("latched_src1", 64'(src1), 64'(32'h11));
    execute = 1;
    tick();

    // Fill, ignored overflow, free one, reuse
    for (int i = 0; i < 4; i++) begin
      idle();
      disp(1, 1, data_t'(i + 10), data_t'(i + 20), 3'd0, 3'd0, tag_t'(i), 4'd3);
      tick();
    end
    idle();
    #1;
    chk("fill_full", 64'(full), 64'(1));
    disp(1, 1, 32'd99, 32'd98, 3'd0, 3'd0, 3'd7, 4'd4);
    tick();
    idle();
    #1;
    chk("overflow_full", 64'(full), 64'(1));
    execute = 1;
    tick();
    idle();
    #1;
    chk("freed_full", 64'(full), 64'(0));
    disp(1, 1, 32'd50, 32'd51, 3'd0, 3'd0, 3'd5, 4'd6);
    tick();
    idle();
    #1;
    chk("reuse_full", 64'(full), 64'(1));

    // Flush qualified by validCommit only
    clear = 1;
    tick();
    idle();
    #1;
    chk("noflush_full", 64'(full), 64'(1));
    clear = 1; validCommit = 1; execute = 1;
    disp(1, 1, 32'd7, 32'd8, 3'd0, 3'd0, 3'd2, 4'd1);
    tick();
    idle();
    #1;
    chk("flush_full", 64'(full), 64'(0));
    chk("flush_issueValid", 64'(issueValid), 64'(0));
    tick();

    // Slot 2 older than slot 0, both ready
    disp(0, 1, 32'd0, 32'd1, 3'd5, 3'd0, 3'd1, 4'd1);
    tick();
    idle();
    disp(0, 1, 32'd0, 32'd2, 3'd6, 3'd0, 3'd2, 4'd1);
    tick();
    idle();
    disp(0, 1, 32'd0, 32'd3, 3'd7, 3'd0, 3'd3, 4'd1);
    tick();
    idle();
    bcast(3'd5, 32'h55);
    execute = 1;
    tick();
    idle();
    bcast(3'd7, 32'h77);
    disp(1, 1, 32'h44, 32'h45, 3'd0, 3'd0, 3'd4, 4'd3);
    #1;
    chk("order_wake_rob", 64'(instrRob), 64'(3'd3));
    tick();
`ifdef ALU_RS_AGE_SELECT_EN
    exp_first = 3'd3; exp_second = 3'd4;
`else
    exp_first = 3'd4; exp_second = 3'd3;
`endif
    idle();
    #1;
    chk("order_first", 64'(instrRob), 64'(exp_first));
    execute = 1;
    tick();
    idle();
    #1;
    chk("order_second", 64'(instrRob), 64'(exp_second));
    execute = 1;
    tick();
    idle();
    clear = 1; validCommit = 1;
    tick();

    // Async reset with three busy slots
    for (int i = 0; i < 3; i++) begin
      idle();
      disp(1, 1, data_t'(i), data_t'(i), 3'd0, 3'd0, tag_t'(i), 4'd5);
      tick();
    end
    idle();
    #1;
    chk("prereset_issueValid", 64'(issueValid), 64'(1));
    globalResetN = 0;
    #1;
    chk("async_full", 64'(full), 64'(0));
    chk("async_issueValid", 64'(issueValid), 64'(0));
    tick();
    #1;
    chk("midreset_instrInfo", 64'(instrInfo), 64'(4'hF));
    chk("midreset_issueValid", 64'(issueValid), 64'(0));
    globalResetN = 1;
    tick();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(99) < 60 && !m_full())
        disp(1'($urandom_range(1)), 1'($urandom_range(1)), data_t'($urandom()),
             data_t'($urandom()), tag_t'($urandom_range(7)), tag_t'($urandom_range(7)),
             tag_t'($urandom_range(7)), ctl_t'($urandom_range(15)));
      if ($urandom_range(1) == 1) bcast(tag_t'($urandom_range(7)), data_t'($urandom()));
      execute = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 4) begin
        clear = 1;
        validCommit = 1'($urandom_range(1));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
